// File: rtl/max7219_pkg.sv
// MAX7219 register map, word-sequence constants and the shifter FSM encoding.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package max7219_pkg;

  // MAX7219 register addresses
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIM   = 4'hB;
  localparam logic [3:0] REG_DISPTEST  = 4'hF;
  localparam logic [3:0] REG_DIGIT0    = 4'h1;

  // Word sequence: indices 0..INIT_WORDS-1 are init, then digits up to LAST_INDEX
  localparam int INIT_WORDS = 5;
  localparam int LAST_INDEX = 12;
  localparam int WORD_BITS  = 16;

  typedef enum logic [1:0] {
    ST_LOAD_WORD = 2'd0,
    ST_SHIFT_LO  = 2'd1,
    ST_SHIFT_HI  = 2'd2,
    ST_LATCH     = 2'd3
  } shift_state_e;

  // Serial word layout: four don't-care zeros, register address, data byte
  function automatic logic [15:0] make_word(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

  // Bit-reverse a row byte for modules mounted flipped
  function automatic logic [7:0] bit_reverse8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_word_shifter.sv
// Shifts one 16-bit word MSB first on DIN/SCLK and latches it with a LOAD pulse.
// Latency: word period 1 + 34*CLK_DIV clocks; outputs are registered (one clock behind state).
// Backpressure: waits in LOAD_WORD until start_vld; done_vld pulses for one clock as LATCH ends.
module spi_word_shifter
  import max7219_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_vld,
  input  logic [15:0] word_dat,
  output logic        done_vld,
  output logic        din,
  output logic        sclk,
  output logic        load
);

  // Prescaler must reach 2*CLK_DIV-1 during LATCH
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] PHASE_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [3:0]       BIT_LAST   = 4'(WORD_BITS - 1);

  shift_state_e     state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [15:0]      sr_q, sr_d;
  logic             din_q, din_d;
  logic             sclk_q, sclk_d;
  logic             load_q, load_d;
  logic             done;

  // Next-state and next-output decode; the pins show this decode one clock later
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    din_d   = 1'b0;
    sclk_d  = 1'b0;
    load_d  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_LOAD_WORD: begin
        if (start_vld) begin
          sr_d    = word_dat;
          div_d   = '0;
          bit_d   = '0;
          din_d   = word_dat[15];
          state_d = ST_SHIFT_LO;
        end else begin
          load_d  = 1'b1;
        end
      end
      ST_SHIFT_LO: begin
        din_d = sr_q[15];
        if (div_q == PHASE_LAST) begin
          div_d   = '0;
          state_d = ST_SHIFT_HI;
        end else begin
          div_d   = div_q + DIV_W'(1);
        end
      end
      ST_SHIFT_HI: begin
        sclk_d = 1'b1;
        din_d  = sr_q[15];
        if (div_q == PHASE_LAST) begin
          div_d = '0;
          sr_d  = {sr_q[14:0], 1'b0};
          bit_d = bit_q + 4'd1;
          if (bit_q == BIT_LAST) begin
            state_d = ST_LATCH;
          end else begin
            state_d = ST_SHIFT_LO;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_LATCH: begin
        load_d = 1'b1;
        if (div_q == LATCH_LAST) begin
          div_d   = '0;
          done    = 1'b1;
          state_d = ST_LOAD_WORD;
        end else begin
          div_d   = div_q + DIV_W'(1);
        end
      end
    endcase
  end

  // State, counters and registered pins; reset drives the link idle immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD_WORD;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      din_q   <= 1'b0;
      sclk_q  <= 1'b0;
      load_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      din_q   <= din_d;
      sclk_q  <= sclk_d;
      load_q  <= load_d;
    end
  end

  assign done_vld = done;
  assign din      = din_q;
  assign sclk     = sclk_q;
  assign load     = load_q;

endmodule

// File: rtl/max7219_matrix_driver.sv
// Streams init then 8 row words per frame to a MAX7219 8x8 module; MAX7219_MIRROR_EN bit-reverses row bytes.
// Latency: rows snapshotted as digit 1 enters LOAD_WORD; each word takes 1 + 34*CLK_DIV clocks.
// Backpressure: none; the link free-runs, row changes mid-frame wait for the next snapshot.
module max7219_matrix_driver
  import max7219_pkg::*;
#(
  parameter int         DATAWIDTH = 8,
  parameter int         CLK_DIV   = 4,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic                 MAX7219_CLOCK_50,
  input  logic                 MAX7219_RESET_InLow,
  input  logic [DATAWIDTH-1:0] MAX7219_Fila1_In,
  input  logic [DATAWIDTH-1:0] MAX7219_Fila2_In,
  input  logic [DATAWIDTH-1:0] MAX7219_Fila3_In,
  input  logic [DATAWIDTH-1:0] MAX7219_Fila4_In,
  input  logic [DATAWIDTH-1:0] MAX7219_Fila5_In,
  input  logic [DATAWIDTH-1:0] MAX7219_Fila6_In,
  input  logic [DATAWIDTH-1:0] MAX7219_Fila7_In,
  input  logic [DATAWIDTH-1:0] MAX7219_Fila8_In,
  output logic                 MAX7219_DIN_Out,
  output logic                 MAX7219_SCLK_Out,
  output logic                 MAX7219_LOAD_Out,
  output logic                 MAX7219_FrameDone_Out
);

  localparam logic [3:0] FIRST_DIGIT_IDX = 4'(INIT_WORDS);
  localparam logic [3:0] LAST_IDX        = 4'(LAST_INDEX);

  logic                      clk;
  logic                      rst_n;
  logic [7:0][DATAWIDTH-1:0] row_in;
  logic [7:0][DATAWIDTH-1:0] snap_q, snap_d;
  logic [3:0]                index_q, index_d;
  logic                      frame_done_q, frame_done_d;
  logic [2:0]                digit_sel;
  logic [7:0]                tx_byte;
  logic [15:0]               word_dat;
  logic                      done_vld;

  assign clk   = MAX7219_CLOCK_50;
  assign rst_n = MAX7219_RESET_InLow;

  assign row_in[0] = MAX7219_Fila1_In;
  assign row_in[1] = MAX7219_Fila2_In;
  assign row_in[2] = MAX7219_Fila3_In;
  assign row_in[3] = MAX7219_Fila4_In;
  assign row_in[4] = MAX7219_Fila5_In;
  assign row_in[5] = MAX7219_Fila6_In;
  assign row_in[6] = MAX7219_Fila7_In;
  assign row_in[7] = MAX7219_Fila8_In;

  // Build the word for the current index; digits read only the frozen snapshot
  always_comb begin
    digit_sel = 3'(index_q - FIRST_DIGIT_IDX);
`ifdef MAX7219_MIRROR_EN
    tx_byte   = bit_reverse8(snap_q[digit_sel]);
`else
    tx_byte   = snap_q[digit_sel];
`endif
    word_dat  = 16'h0000;
    unique case (index_q)
      4'd0:    word_dat = make_word(REG_SHUTDOWN, 8'h01);
      4'd1:    word_dat = make_word(REG_DECODE, 8'h00);
      4'd2:    word_dat = make_word(REG_INTENSITY, {4'h0, INTENSITY});
      4'd3:    word_dat = make_word(REG_SCANLIM, 8'h07);
      4'd4:    word_dat = make_word(REG_DISPTEST, 8'h00);
      default: word_dat = make_word(REG_DIGIT0 + 4'(digit_sel), tx_byte);
    endcase
  end

  // Advance the index per latched word, wrap past digit 8, snapshot rows as digit 1 comes up
  always_comb begin
    index_d      = index_q;
    snap_d       = snap_q;
    frame_done_d = 1'b0;
    if (done_vld) begin
      if (index_q == LAST_IDX) begin
        index_d      = FIRST_DIGIT_IDX;
        frame_done_d = 1'b1;
      end else begin
        index_d      = index_q + 4'd1;
      end
      if (index_d == FIRST_DIGIT_IDX) begin
        snap_d = row_in;
      end
    end
  end

  // Word index, row snapshot and frame-done pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q      <= '0;
      snap_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      index_q      <= index_d;
      snap_q       <= snap_d;
      frame_done_q <= frame_done_d;
    end
  end

  spi_word_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_vld (1'b1),
    .word_dat  (word_dat),
    .done_vld  (done_vld),
    .din       (MAX7219_DIN_Out),
    .sclk      (MAX7219_SCLK_Out),
    .load      (MAX7219_LOAD_Out)
  );

  assign MAX7219_FrameDone_Out = frame_done_q;

endmodule

// File: tb/tb_max7219_matrix_driver.sv
// Directed bench for max7219_matrix_driver: SPI word capture, frame sequencing and link timing.
// Latency: expects 1 + 34*CLK_DIV clocks per word (103 at CLK_DIV=3).
// Backpressure: none; the DUT free-runs and the bench only observes.
module tb_max7219_matrix_driver;

  localparam int CLK_DIV = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] f1, f2, f3, f4, f5, f6, f7, f8;
  logic       din, sclk, load, fd;

  int tests = 0;
  int fails = 0;

  max7219_matrix_driver #(
    .DATAWIDTH (8),
    .CLK_DIV   (CLK_DIV),
    .INTENSITY (4'h8)
  ) dut (
    .MAX7219_CLOCK_50      (clk),
    .MAX7219_RESET_InLow   (rst_n),
    .MAX7219_Fila1_In      (f1),
    .MAX7219_Fila2_In      (f2),
    .MAX7219_Fila3_In      (f3),
    .MAX7219_Fila4_In      (f4),
    .MAX7219_Fila5_In      (f5),
    .MAX7219_Fila6_In      (f6),
    .MAX7219_Fila7_In      (f7),
    .MAX7219_Fila8_In      (f8),
    .MAX7219_DIN_Out       (din),
    .MAX7219_SCLK_Out      (sclk),
    .MAX7219_LOAD_Out      (load),
    .MAX7219_FrameDone_Out (fd)
  );

  always #10 clk = ~clk;

  // Hand-computed expected words
  logic [15:0] exp_init [5] = '{16'h0C01, 16'h0900, 16'h0A08, 16'h0B07, 16'h0F00};
  logic [15:0] exp_f1   [8] = '{16'h0181, 16'h0242, 16'h0324, 16'h0418,
                                16'h0518, 16'h0624, 16'h0742, 16'h0881};
`ifdef MAX7219_MIRROR_EN
  logic [15:0] exp_d1_f3 = 16'h0180;
  logic [15:0] exp_d2_f3 = 16'h0203;
`else
  logic [15:0] exp_d1_f3 = 16'h0101;
  logic [15:0] exp_d2_f3 = 16'h02C0;
`endif

  // SPI monitor: shift DIN on SCLK rise, frame a word on LOAD rise
  logic [15:0] mon_sr = 16'h0;
  int          mon_bits = 0;
  int          total_words = 0;
  logic [15:0] cap_q [$];

  always @(posedge sclk or posedge load) begin
    if (load) begin
      if (mon_bits == 16) begin
        cap_q.push_back(mon_sr);
        total_words = total_words + 1;
      end
      mon_bits = 0;
    end else begin
      mon_sr   = {mon_sr[14:0], din};
      mon_bits = mon_bits + 1;
    end
  end

  // Timing and FrameDone monitor, sampled on the falling clock edge
  int   cyc = 0;
  logic p_sclk = 1'b0, p_load = 1'b1, p_din = 1'b0, p_fd = 1'b0;
  int   s_run = 0, l_run = 0, din_age = 0, rises_in_word = 0;
  int   last_rise = 0, n_bad = 0;
  int   last_hi = 0, last_lo = 0, last_lhi = 0, last_per = 0;
  bit   have_rise = 1'b0;
  int   fd_run = 0, fd_max_w = 0, fd_pulses = 0, fd_first_words = -1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      p_sclk = 1'b0; p_load = 1'b1; p_din = 1'b0; p_fd = 1'b0;
      s_run = 0; l_run = 0; din_age = 0; rises_in_word = 0;
      have_rise = 1'b0; fd_run = 0;
    end else begin
      din_age = (din !== p_din) ? 1 : din_age + 1;
      if (sclk !== p_sclk) begin
        if (p_sclk) begin
          last_hi = s_run;
          if (s_run != CLK_DIV) n_bad = n_bad + 1;
        end else begin
          if (rises_in_word > 0) begin
            last_lo = s_run;
            if (s_run != CLK_DIV) n_bad = n_bad + 1;
          end
          if (din_age < CLK_DIV + 1) n_bad = n_bad + 1;
          rises_in_word = rises_in_word + 1;
        end
        s_run = 1;
      end else begin
        s_run = s_run + 1;
        if (sclk && din !== p_din) n_bad = n_bad + 1;
      end
      if (load !== p_load) begin
        if (load) begin
          if (sclk) n_bad = n_bad + 1;
          if (have_rise) begin
            last_per = cyc - last_rise;
            if (last_per != 103) n_bad = n_bad + 1;
          end
          have_rise = 1'b1;
          last_rise = cyc;
          rises_in_word = 0;
        end else if (have_rise) begin
          last_lhi = l_run;
          if (l_run != 2 * CLK_DIV) n_bad = n_bad + 1;
        end
        l_run = 1;
      end else begin
        l_run = l_run + 1;
      end
      if (fd) begin
        if (!p_fd) begin
          if (fd_pulses == 0) fd_first_words = total_words;
          fd_pulses = fd_pulses + 1;
        end
        fd_run = fd_run + 1;
        if (fd_run > fd_max_w) fd_max_w = fd_run;
      end else begin
        fd_run = 0;
      end
      p_sclk = sclk; p_load = load; p_din = din; p_fd = fd;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests = tests + 1;
    assert (got === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_words(input int n);
    int k;
    k = 0;
    while (cap_q.size() < n && k < 5000) begin
      @(posedge clk);
      k++;
    end
    if (cap_q.size() < n) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL wait_words: observed %0d words, expected %0d", cap_q.size(), n);
    end
  endtask

  initial begin
    int k;
    f1 = 8'h81; f2 = 8'h42; f3 = 8'h24; f4 = 8'h18;
    f5 = 8'h18; f6 = 8'h24; f7 = 8'h42; f8 = 8'h81;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_load", {31'd0, load}, 32'd1);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_din",  {31'd0, din},  32'd0);
    check("rst_fd",   {31'd0, fd},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Change row 1 while digit 3 is being shifted
    wait_words(7);
    repeat (20) @(posedge clk);
    f1 = 8'hFF;

    wait_words(14);
    for (int i = 0; i < 5; i++) check($sformatf("init%0d", i), {16'd0, cap_q[i]}, {16'd0, exp_init[i]});
    for (int i = 0; i < 8; i++) check($sformatf("f1_digit%0d", i + 1), {16'd0, cap_q[5 + i]}, {16'd0, exp_f1[i]});
    check("f2_digit1",      {16'd0, cap_q[13]}, 32'h0000_01FF);
    check("fd_pulses",      fd_pulses,          32'd1);
    check("fd_after_word",  fd_first_words,     32'd13);
    check("fd_width",       fd_max_w,           32'd1);

    // Rows changed mid-frame 2 take effect only in frame 3
    f1 = 8'h01; f2 = 8'hC0;
    wait_words(23);
    check("f2_digit2", {16'd0, cap_q[14]}, 32'h0000_0242);
    check("f3_digit1", {16'd0, cap_q[21]}, {16'd0, exp_d1_f3});
    check("f3_digit2", {16'd0, cap_q[22]}, {16'd0, exp_d2_f3});

    // Link timing at CLK_DIV=3
    check("timing_violations", n_bad,    32'd0);
    check("sclk_high_clks",    last_hi,  32'd3);
    check("sclk_low_clks",     last_lo,  32'd3);
    check("load_high_clks",    last_lhi, 32'd6);
    check("word_period_clks",  last_per, 32'd103);

    // Reset in the middle of the 0x0B07 word
    rst_n = 1'b0;
    @(negedge clk);
    cap_q.delete();
    rst_n = 1'b1;
    k = 0;
    while (!(cap_q.size() == 3 && mon_bits == 7) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("midword_reached", {31'd0, (cap_q.size() == 3 && mon_bits == 7)}, 32'd1);
    check("midword_sclk_hi", {31'd0, sclk}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_load", {31'd0, load}, 32'd1);
    check("midrst_sclk", {31'd0, sclk}, 32'd0);
    check("midrst_din",  {31'd0, din},  32'd0);
    @(negedge clk);
    cap_q.delete();
    rst_n = 1'b1;
    wait_words(1);
    check("restart_word", {16'd0, cap_q[0]}, 32'h0000_0C01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
